// File: rtl/matrix_fetch_ctrl_pkg.sv
// Shared types and default geometry for the VGA tile-matrix fetch sequencer.
package vga_mem_pkg;

    localparam int ROWS   = 10;
    localparam int COLS   = 10;
    localparam int CELL_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DRAIN  = ST_DRAIN,
        S_COMMIT = ST_COMMIT
    } fetch_state_t;

    typedef enum logic {
        OWN_CPU   = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

endpackage

// File: rtl/matrix_fetch_ctrl_if.sv
// CPU load path and single-port data RAM read bus seen by the fetch sequencer.
interface matrix_fetch_ctrl_if #(
    parameter int ADDR_W = 11
) ();

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    modport master (
        input  cpu_req, cpu_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, mem_en, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, mem_en, mem_addr
    );

endinterface

// File: rtl/matrix_fetch_ctrl_arb.sv
// RAM read-port arbiter: CPU has priority, fetch wins after MAX_WAIT consecutive denials.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic fetch_req,
    output logic cpu_gnt,
    output logic fetch_gnt,
    output logic mem_en
);
    import vga_mem_pkg::*;

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             fetch_forced;

    always_comb begin
        fetch_forced = fetch_req && (wait_cnt == CNT_W'(MAX_WAIT));
        cpu_gnt      = cpu_req && !fetch_forced;
        fetch_gnt    = fetch_req && !cpu_gnt;
        mem_en       = cpu_gnt || fetch_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (fetch_gnt) begin
            wait_cnt <= '0;
        end else if (fetch_req) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_fetch_ctrl.sv
// Refreshes the VGA tile matrix one RAM word per cycle into a shadow buffer,
// then commits the whole frame to the display buffer in a single edge.
module matrix_fetch_ctrl #(
    parameter int ROWS      = vga_mem_pkg::ROWS,
    parameter int COLS      = vga_mem_pkg::COLS,
    parameter int CELL_W    = vga_mem_pkg::CELL_W,
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              overrun_clr,
    matrix_fetch_ctrl_if.master bus,
    output logic [CELL_W-1:0] matriz [ROWS][COLS],
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);
    import vga_mem_pkg::*;

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    fetch_state_t     state;
    logic [IDX_W-1:0] idx;
    logic             fetch_req;
    logic             fetch_gnt;
    logic             cpu_gnt;
    logic             mem_en;
    logic             pend_valid;
    owner_t           pend_owner;
    logic [IDX_W-1:0] pend_idx;
    logic             shadow_we;
    logic             unused_rdata_hi;

    assign fetch_req = (state == S_FETCH);
    assign busy      = (state != S_IDLE);

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (bus.cpu_req),
        .fetch_req (fetch_req),
        .cpu_gnt   (cpu_gnt),
        .fetch_gnt (fetch_gnt),
        .mem_en    (mem_en)
    );

    assign bus.cpu_gnt  = cpu_gnt;
    assign bus.mem_en   = mem_en;
    assign bus.mem_addr = fetch_gnt ? (ADDR_W'(BASE_ADDR) + ADDR_W'(idx)) : bus.cpu_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && state != S_IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (frame_start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_gnt) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN:  state <= S_COMMIT;
                S_COMMIT: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // One outstanding read: remembers who owns the data returning next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_owner <= OWN_CPU;
            pend_idx   <= '0;
        end else begin
            pend_valid <= mem_en;
            pend_owner <= fetch_gnt ? OWN_FETCH : OWN_CPU;
            pend_idx   <= idx;
        end
    end

    assign bus.cpu_rvalid  = pend_valid && (pend_owner == OWN_CPU);
    assign shadow_we       = pend_valid && (pend_owner == OWN_FETCH);
    assign unused_rdata_hi = ^bus.mem_rdata[31:CELL_W];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [CELL_W-1:0] shadow;
            logic [CELL_W-1:0] disp;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow <= '0;
                    disp   <= '0;
                end else begin
                    if (shadow_we && pend_idx == IDX_W'(r * COLS + c)) begin
                        shadow <= bus.mem_rdata[CELL_W-1:0];
                    end
                    if (state == S_COMMIT) disp <= shadow;
                end
            end

            assign matriz[r][c] = disp;
        end
    end

endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// Directed bench for matrix_fetch_ctrl: frame latency, arbitration, overrun, reset and address wrap.
`timescale 1ns/1ps
module tb_matrix_fetch_ctrl;
    import vga_mem_pkg::*;

    typedef struct {
        int    r;
        int    c;
        cell_t exp_base;
        cell_t exp_wrap;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  frame_start, frame_start2, overrun_clr;
    logic  busy, frame_done, overrun;
    logic  busy2, frame_done2, overrun2;
    cell_t matriz  [ROWS][COLS];
    cell_t matriz2 [ROWS][COLS];
    logic [31:0] ram [2048];

    int checks   = 0;
    int failures = 0;

    matrix_fetch_ctrl_if #(.ADDR_W(11)) bus  ();
    matrix_fetch_ctrl_if #(.ADDR_W(11)) bus2 ();

    matrix_fetch_ctrl #(
        .ROWS(10), .COLS(10), .CELL_W(4), .ADDR_W(11), .BASE_ADDR(0), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .overrun_clr(overrun_clr),
        .bus(bus), .matriz(matriz), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    matrix_fetch_ctrl #(
        .ROWS(10), .COLS(10), .CELL_W(4), .ADDR_W(11), .BASE_ADDR(2040), .MAX_WAIT(4)
    ) dut_wrap (
        .clk(clk), .rst(rst), .frame_start(frame_start2), .overrun_clr(overrun_clr),
        .bus(bus2), .matriz(matriz2), .busy(busy2), .frame_done(frame_done2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en)  bus.mem_rdata  <= ram[bus.mem_addr];
        if (bus2.mem_en) bus2.mem_rdata <= ram[bus2.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int base_errors();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (matriz[r][c] !== cell_t'((10 * r + c + 1) % 16)) n++;
        return n;
    endfunction

    // Sample k observes the cycle between E(k) and E(k+1), E0 being the edge that sees frame_start.
    task automatic run_frame(input int ovr_at, input int both_at, input int poke_at, input bit chk_slot,
                             output int lat, output int bad_busy, output int fetch_grants,
                             output int bad_slot, output int bad_rvalid, output int bad_addr);
        bit prev_gnt;
        int exp_idx = 0;
        lat = -1; bad_busy = 0; fetch_grants = 0; bad_slot = 0; bad_rvalid = 0; bad_addr = 0;
        frame_start = 1'b1;
        #1;
        prev_gnt = bus.cpu_gnt;
        tick();
        for (int k = 0; k < 1000; k++) begin
            frame_start = (k == ovr_at) || (k == both_at);
            overrun_clr = (k == both_at);
            if (k == poke_at) ram[0] = 32'h7;
            #1;
            if (bus.cpu_rvalid !== prev_gnt) bad_rvalid++;
            if (frame_done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if (bus.mem_en && !bus.cpu_gnt) begin
                fetch_grants++;
                if (bus.mem_addr !== 11'(exp_idx)) bad_addr++;
                if (chk_slot && (k % 5) != 4) bad_slot++;
                exp_idx++;
            end
            prev_gnt = bus.cpu_gnt;
            tick();
        end
        frame_start = 1'b0;
        overrun_clr = 1'b0;
    endtask

    initial begin
        vec_t tbl [7];
        int lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr, cnt;

        tbl[0] = '{0, 0, 4'd1,  4'd9};
        tbl[1] = '{0, 7, 4'd8,  4'd0};
        tbl[2] = '{0, 8, 4'd9,  4'd1};
        tbl[3] = '{1, 5, 4'd0,  4'd8};
        tbl[4] = '{5, 3, 4'd6,  4'd14};
        tbl[5] = '{9, 9, 4'd4,  4'd12};
        tbl[6] = '{3, 2, 4'd1,  4'd9};

        for (int i = 0; i < 2048; i++) ram[i] = 32'(i + 1);
        rst = 1'b1; frame_start = 1'b0; frame_start2 = 1'b0; overrun_clr = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 11'd5;
        bus2.cpu_req = 1'b0; bus2.cpu_addr = '0;
        repeat (3) tick();

        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        check("rst_cpu_gnt", bus.cpu_gnt, 1);
        check("rst_mem_addr", bus.mem_addr, 5);
        cnt = 0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (matriz[r][c] !== 4'd0) cnt++;
        check("rst_matriz_zero", cnt, 0);

        bus.cpu_req = 1'b0;
        rst = 1'b0;
        tick();

        // Idle bus: 102-cycle frame
        run_frame(-1, -1, -1, 0, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t1_latency", lat, 102);
        check("t1_busy", bad_busy, 0);
        check("t1_fetch_grants", fgr, 100);
        check("t1_addr", bad_addr, 0);
        check("t1_rvalid", bad_rv, 0);
        check("t1_busy_after", busy, 0);
        for (int i = 0; i < 7; i++)
            check($sformatf("t1_cell_%0d_%0d", tbl[i].r, tbl[i].c), matriz[tbl[i].r][tbl[i].c], tbl[i].exp_base);
        check("t1_all_cells", base_errors(), 0);

        // Continuous CPU traffic: fetch only on forced slots
        bus.cpu_req = 1'b1; bus.cpu_addr = 11'd5;
        run_frame(-1, -1, -1, 1, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t2_latency", lat, 502);
        check("t2_fetch_grants", fgr, 100);
        check("t2_slots", bad_slot, 0);
        check("t2_rvalid", bad_rv, 0);
        check("t2_addr", bad_addr, 0);
        check("t2_all_cells", base_errors(), 0);
        bus.cpu_addr = 11'd33;
        #1;
        check("t2_idle_gnt", bus.cpu_gnt, 1);
        tick();
        check("t2_cpu_rvalid", bus.cpu_rvalid, 1);
        check("t2_cpu_rdata", bus.mem_rdata, 34);
        bus.cpu_req = 1'b0;
        tick();
        check("t2_cpu_rvalid_drop", bus.cpu_rvalid, 0);

        // Overrun, including simultaneous set and clear
        check("t3_overrun_pre", overrun, 0);
        run_frame(50, 60, -1, 0, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t3_latency", lat, 102);
        check("t3_overrun_set", overrun, 1);
        check("t3_all_cells", base_errors(), 0);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        check("t3_overrun_clr", overrun, 0);

        // frame_start during COMMIT is ignored
        run_frame(101, -1, -1, 0, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t3c_latency", lat, 102);
        check("t3c_overrun", overrun, 1);
        repeat (3) tick();
        check("t3c_not_restarted", busy, 0);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;

        // RAM word 0 changes after it was fetched
        run_frame(-1, -1, 10, 0, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t4_cell00_old", matriz[0][0], 1);
        check("t4_cell01", matriz[0][1], 2);
        run_frame(-1, -1, -1, 0, lat, bad_busy, fgr, bad_slot, bad_rv, bad_addr);
        check("t4_cell00_new", matriz[0][0], 7);
        ram[0] = 32'd1;

        // Reset in the middle of a frame
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (60) tick();
        check("t5_display_stable", matriz[0][0], 7);
        check("t5_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        cnt = 0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (matriz[r][c] !== 4'd0) cnt++;
        check("t5_matriz_zero", cnt, 0);
        check("t5_busy", busy, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (frame_done !== 1'b0) cnt++;
        end
        check("t5_no_frame_done", cnt, 0);
        check("t5_busy_after", busy, 0);

        // BASE_ADDR near the top of the address space wraps to 0
        frame_start2 = 1'b1; tick(); frame_start2 = 1'b0;
        lat = -1; bad_addr = 0;
        for (int k = 0; k < 1000; k++) begin
            if (frame_done2 === 1'b1) begin
                lat = k;
                break;
            end
            if (bus2.mem_en && bus2.mem_addr !== 11'((2040 + k) % 2048)) bad_addr++;
            tick();
        end
        check("t6_latency", lat, 102);
        check("t6_addr", bad_addr, 0);
        for (int i = 0; i < 7; i++)
            check($sformatf("t6_cell_%0d_%0d", tbl[i].r, tbl[i].c), matriz2[tbl[i].r][tbl[i].c], tbl[i].exp_wrap);
        cnt = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (matriz2[r][c] !== cell_t'((((2040 + 10 * r + c) % 2048) + 1) % 16)) cnt++;
        check("t6_all_cells", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_fetch_ctrl.md
# matrix_fetch_ctrl

Sequencer that refreshes the VGA tile matrix from the CPU data memory one word per cycle, replacing a fully parallel 100-word read. It sits between the shared single-port data RAM, the CPU load/store path and the VGA renderer. It arbitrates the RAM read port, fills a shadow buffer at each frame start, and commits it atomically to the display buffer so the renderer never shows a torn frame.

## Interface
- ROWS, 10, matrix rows
- COLS, 10, matrix columns
- CELL_W, 4, bits per cell, taken from word LSBs
- ADDR_W, 11, RAM word-address width
- BASE_ADDR, 0, word address of cell [0][0], row-major
- MAX_WAIT, 4, consecutive fetch denials before fetch is forced to win
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse from VGA vsync
- overrun_clr  in  1  clears overrun
- cpu_req  in  1  CPU read request, held until granted
- cpu_addr  in  ADDR_W  CPU word address
- cpu_gnt  out  1  combinational grant for this cycle
- cpu_rvalid  out  1  mem_rdata belongs to CPU, one cycle after grant
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM address
- mem_rdata  in  32  RAM data, valid one cycle after mem_en
- matriz  out  CELL_W x [ROWS][COLS]  display buffer
- busy  out  1  fetch in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse, display buffer updated
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, FETCH, DRAIN, COMMIT.
- IDLE: frame_start -> FETCH. Issue index and wait counter are cleared.
- FETCH: fetch requests the port every cycle.
  - On a fetch grant: mem_addr = BASE_ADDR + idx (mod 2^ADDR_W) and idx increments.
  - After the grant of idx ROWS*COLS-1 -> DRAIN.
- DRAIN: waits one cycle for the last data, then -> COMMIT.
- COMMIT: display <= shadow in one cycle, frame_done pulses, then -> IDLE.
- Arbitration is fixed priority, CPU first:
  - The fetch wins only when cpu_req=0, or when the wait counter equals MAX_WAIT.
  - The wait counter increments on each denied FETCH cycle and clears on each fetch grant.
  - cpu_gnt = cpu_req & ~fetch_forced.
- mem_en = any grant. mem_addr = granted address; it is cpu_addr when no grant.
- Read pipeline register: pending valid, owner and cell index. The cycle after a fetch grant, shadow[idx] <= mem_rdata[CELL_W-1:0]. The cycle after a CPU grant, cpu_rvalid=1.
- A frame_start while state != IDLE (including COMMIT) is ignored and sets overrun. overrun_clr clears it. A simultaneous set and clear leaves overrun set.
- Reset values:
  - State IDLE; matriz and shadow all 0.
  - busy, frame_done, cpu_rvalid and overrun all 0; counters 0.
  - cpu_gnt follows cpu_req.
- Reset mid-fetch abandons the frame; the display reads zeros.

## Timing
- Edge E0 samples frame_start; with no CPU traffic, address k is presented in cycle E(k)–E(k+1).
- shadow[k] is written at E(k+2). shadow[ROWS*COLS-1] is written at E101, and the state enters COMMIT.
- matriz updates at E102; frame_done is high from E102 to E103.
- Each CPU-won cycle adds exactly one cycle to that latency.
- Worst case with continuous cpu_req: fetch gets 1 of every MAX_WAIT+1 cycles, giving a latency of about 500 cycles. This is well under one 640x480 frame (about 420k clocks).
- matriz is stable between commits. No cell changes outside a COMMIT edge.

## Structure
- Package vga_mem_pkg holds:
  - ROWS, COLS and CELL_W constants
  - cell_t (logic [CELL_W-1:0])
  - the fetch_state_t enum
  - owner_t (CPU/FETCH)
- Sub-module mem_port_arbiter: fixed priority plus MAX_WAIT starvation counter. It takes cpu_req and fetch_req and produces cpu_gnt, fetch_gnt and mem_en.

## Test plan
- Preload word n = n+1, no CPU traffic, pulse frame_start -> frame_done 102 cycles later; matriz[r][c] = (10r+c+1) mod 16; busy high throughout.
- cpu_req held high during the fetch, MAX_WAIT=4 -> fetch grant every 5th cycle; cpu_rvalid follows each CPU grant; frame completes with correct data.
- Second frame_start at cycle 50 -> overrun=1; frame completes normally; overrun_clr -> overrun=0.
- Change RAM word 0 to 0x7 mid-fetch after idx 0 was read -> matriz[0][0] keeps the old value until the next frame.
- rst asserted at cycle 60 -> matriz all 0 immediately; busy=0; no frame_done.
- BASE_ADDR=2040 -> addresses wrap to 0..91; cells match those words.
